// File: rtl/booth_pp_accum_pipe.sv
`default_nettype none
// =============================================================================
// booth_pp_accum_pipe
// Sums the two radix-4 Booth partial products per beat and optionally
// accumulates the products (MAC) in a two-register valid/ready pipeline.
// Revision: 1.0
// =============================================================================
module booth_pp_accum_pipe #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_pp0,
   input  logic [7:0]       in_pp1,
   input  logic             in_acc_en,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_prod,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             out_last
);

   localparam int c_PROD_W = 8;

   logic                r_s1_v;
   logic [c_PROD_W-1:0] r_s1_pp0;
   logic [c_PROD_W-1:0] r_s1_pp1;
   logic                r_s1_acc_en;
   logic                r_s1_last;

   logic                r_s2_v;
   logic [c_PROD_W-1:0] r_s2_prod;
   logic [ACC_W-1:0]    r_s2_acc;
   logic                r_s2_ovf;
   logic                r_s2_last;
   logic                r_group_closed;

   logic                w_s1_load;
   logic                w_s2_load;
   logic                w_new_group;
   logic [c_PROD_W-1:0] w_prod;
   logic [ACC_W-1:0]    w_prod_sext;
   logic [ACC_W-1:0]    w_base;
   logic [ACC_W-1:0]    w_sum;
   logic                w_sum_ovf;
   logic                w_ovf_next;

   assign w_s2_load = r_s1_v & (~r_s2_v | out_ready);
   assign in_ready  = ~r_s1_v | w_s2_load;
   assign w_s1_load = in_valid & in_ready;

   // The S2 accumulator register doubles as the running MAC state.
   assign w_new_group = ~r_s1_acc_en | r_group_closed;
   assign w_prod      = r_s1_pp0 + r_s1_pp1;
   assign w_prod_sext = {{(ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
   assign w_base      = w_new_group ? '0 : r_s2_acc;
   assign w_sum       = w_base + w_prod_sext;
   assign w_sum_ovf   = (w_base[ACC_W-1] == w_prod_sext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != w_base[ACC_W-1]);
   assign w_ovf_next  = (w_new_group ? 1'b0 : r_s2_ovf) | w_sum_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v      <= 1'b0;
         r_s1_pp0    <= '0;
         r_s1_pp1    <= '0;
         r_s1_acc_en <= 1'b0;
         r_s1_last   <= 1'b0;
      end else if (w_s1_load) begin
         r_s1_v      <= 1'b1;
         r_s1_pp0    <= in_pp0;
         r_s1_pp1    <= in_pp1;
         r_s1_acc_en <= in_acc_en;
         r_s1_last   <= in_last;
      end else if (w_s2_load) begin
         r_s1_v      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v         <= 1'b0;
         r_s2_prod      <= '0;
         r_s2_acc       <= '0;
         r_s2_ovf       <= 1'b0;
         r_s2_last      <= 1'b0;
         r_group_closed <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_v         <= 1'b1;
         r_s2_prod      <= w_prod;
         r_s2_acc       <= w_sum;
         r_s2_ovf       <= w_ovf_next;
         r_s2_last      <= r_s1_last;
         r_group_closed <= r_s1_last;
      end else if (out_ready) begin
         r_s2_v         <= 1'b0;
      end
   end

   assign out_valid = r_s2_v;
   assign out_prod  = r_s2_prod;
   assign out_acc   = r_s2_acc;
   assign out_ovf   = r_s2_ovf;
   assign out_last  = r_s2_last;

endmodule
`default_nettype wire
